// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'hE1A0_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {REQ, DRAIN, HOLD} state_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
      logic               valid;
   } ifid_t;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch: PC, req/ack memory handshake, freeze buffering, branch
// redirect/flush, and the IF/ID pipeline register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0]        RESET_PC  = RESET_PC_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [31:0]        branch_addr,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [31:0]        PC,
   output logic [INSTR_W-1:0] Instruction,
   output logic               valid
);

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [INSTR_W-1:0] buf_q, buf_d;
   logic [31:0]        tgt_q, tgt_d;
   ifid_t              ifid_q, ifid_d;

   logic [31:0] pc_plus4;
   ifid_t       flushed;

   assign pc_plus4 = pc_q + 32'd4;
   assign flushed  = '{pc: ifid_q.pc, instr: NOP_INSTR, valid: 1'b0};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      tgt_d   = tgt_q;
      ifid_d  = ifid_q;
      case (state_q)
         REQ: begin
            if (branch_taken) begin
               ifid_d = flushed;
               if (imem_ack) begin
                  pc_d = branch_addr;
               end else begin
                  tgt_d   = branch_addr;
                  state_d = DRAIN;
               end
            end else if (imem_ack && !freeze) begin
               ifid_d = '{pc: pc_plus4, instr: imem_rdata, valid: 1'b1};
               pc_d   = pc_plus4;
            end else if (imem_ack) begin
               buf_d   = imem_rdata;
               state_d = HOLD;
            end else if (!freeze) begin
               ifid_d = flushed;
            end
         end
         DRAIN: begin
            // The old request must complete before the target can be fetched;
            // a newer branch seen on the ack cycle still wins.
            ifid_d = flushed;
            if (branch_taken) tgt_d = branch_addr;
            if (imem_ack) begin
               pc_d    = branch_taken ? branch_addr : tgt_q;
               state_d = REQ;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               ifid_d  = flushed;
               pc_d    = branch_addr;
               state_d = REQ;
            end else if (!freeze) begin
               ifid_d  = '{pc: pc_plus4, instr: buf_q, valid: 1'b1};
               pc_d    = pc_plus4;
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         buf_q   <= '0;
         tgt_q   <= '0;
         ifid_q  <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         tgt_q   <= tgt_d;
         ifid_q  <= ifid_d;
      end
   end

   assign imem_req    = !rst && (state_q != HOLD);
   assign imem_addr   = pc_q;
   assign PC          = ifid_q.pc;
   assign Instruction = ifid_q.instr;
   assign valid       = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed + randomized bench for if_stage against a transaction-level model.
module tb_if_stage;
   localparam logic [31:0] NOP = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        rst, freeze, branch_taken, imem_ack, imem_req, valid;
   logic [31:0] branch_addr, imem_addr, imem_rdata, PC, Instruction;

   if_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC),
      .Instruction(Instruction), .valid(valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // model: fetch address, pending redirect, buffered word, IF/ID contents
   logic [31:0] m_pc, m_tgt, m_buf, o_pc, o_ins;
   logic        m_redirect, m_have_buf, o_vld;

   // memory: latency chosen when a request first appears
   bit mem_busy = 0;
   int mem_cnt = 0, mem_lat_cur = 0;
   int mem_lat = 0;   // <0 picks random latency 0..3

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_tgt = 0; m_buf = 0; m_redirect = 0; m_have_buf = 0;
      o_pc = 0; o_ins = NOP; o_vld = 0;
   endtask

   task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] ba);
      logic exp_req, ack;
      logic [31:0] rd;
      @(negedge clk);
      rst = r; freeze = f; branch_taken = b; branch_addr = ba;
      exp_req = !r && !m_have_buf;
      ack = 1'b0;
      if (exp_req) begin
         if (!mem_busy) begin
            mem_busy = 1; mem_cnt = 0;
            mem_lat_cur = (mem_lat < 0) ? int'($urandom_range(3, 0)) : mem_lat;
         end
         ack = (mem_cnt == mem_lat_cur);
         if (ack) mem_busy = 0; else mem_cnt++;
      end
      if (r) mem_busy = 0;
      rd = ack ? word_of(m_pc) : $urandom;
      imem_ack = ack; imem_rdata = rd;
      #1;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      if (r) model_reset();
      else if (m_have_buf) begin
         if (b) begin
            o_ins = NOP; o_vld = 0; m_pc = ba; m_have_buf = 0;
         end else if (!f) begin
            o_pc = m_pc + 4; o_ins = m_buf; o_vld = 1; m_pc = m_pc + 4; m_have_buf = 0;
         end
      end else if (m_redirect) begin
         o_ins = NOP; o_vld = 0;
         if (b) m_tgt = ba;
         if (ack) begin m_pc = m_tgt; m_redirect = 0; end
      end else if (b) begin
         o_ins = NOP; o_vld = 0;
         if (ack) m_pc = ba; else begin m_tgt = ba; m_redirect = 1; end
      end else if (ack && f) begin
         m_buf = rd; m_have_buf = 1;
      end else if (ack) begin
         o_pc = m_pc + 4; o_ins = rd; o_vld = 1; m_pc = m_pc + 4;
      end else if (!f) begin
         o_ins = NOP; o_vld = 0;
      end
      @(posedge clk);
      #1;
      chk("ifid_pc", PC, o_pc);
      chk("ifid_instr", Instruction, o_ins);
      chk("ifid_valid", {31'b0, valid}, {31'b0, o_vld});
   endtask

   initial begin
      rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0; imem_ack = 0; imem_rdata = 0;
      model_reset();
      // reset
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      chk("reset_instr", Instruction, NOP);
      // zero-wait streaming
      mem_lat = 0;
      repeat (5) cyc(0, 0, 0, 0);
      chk("stream_pc", PC, 32'd20);
      // 3-cycle memory: bubbles then word
      mem_lat = 3;
      repeat (8) cyc(0, 0, 0, 0);
      // freeze in ack cycle, held four cycles
      mem_lat = 0;
      repeat (2) cyc(0, 0, 0, 0);
      repeat (4) cyc(0, 1, 0, 0);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      cyc(0, 0, 0, 0);
      chk("release_valid", {31'b0, valid}, 32'd1);
      cyc(0, 0, 0, 0);
      // branch while a 2-cycle request is pending
      mem_lat = 2;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 32'h40);
      cyc(0, 0, 0, 0);
      chk("drain_redirect", imem_addr, 32'h40);
      repeat (3) cyc(0, 0, 0, 0);
      // branch + freeze together in HOLD
      mem_lat = 0;
      cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 32'h80);
      chk("hold_flush_valid", {31'b0, valid}, 32'd0);
      cyc(0, 0, 0, 0);
      // PC wrap
      cyc(0, 0, 1, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0);
      chk("wrap_pc", PC, 32'h0);
      cyc(0, 0, 0, 0);
      // reset mid-request
      mem_lat = 3;
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("rst_pc", imem_addr, 32'h0);
      cyc(0, 0, 0, 0);
      // randomized
      mem_lat = -1;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(99, 0) == 0),
             ($urandom_range(3, 0) == 0),
             ($urandom_range(9, 0) == 0),
             {$urandom_range(32'h3FFF, 0), 2'b00} | (($urandom_range(7, 0) == 0) ? 32'hFFFF_0000 : 32'h0));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
